// File: rtl/sig_shift_ctrl_if.sv
// Operand-set handshake bundle for sig_shift_ctrl: input beat channel plus
// the registered shifter-operand channel returned downstream.
interface sig_shift_ctrl_if #(
  parameter int expWidth = 4,
  parameter int sigWidth = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [expWidth*4-1:0]   in_exp;
  logic [sigWidth*4-1:0]   in_sig;
  logic [3:0]              in_sign;
  logic [1:0]              in_op;
  logic                    out_valid;
  logic                    out_ready;
  logic [expWidth*4-1:0]   exp_offset_num;
  logic [sigWidth*4-1:0]   significand;
  logic [3:0]              sign;
  logic [3:0]              complement_sign1;
  logic [3:0]              complement_sign2;
  logic [expWidth-1:0]     max_exp;
  logic [15:0]             beat_cnt;

  modport master (
    output in_valid, in_exp, in_sig, in_sign, in_op, out_ready,
    input  in_ready, out_valid, exp_offset_num, significand, sign,
           complement_sign1, complement_sign2, max_exp, beat_cnt
  );

  modport slave (
    input  in_valid, in_exp, in_sig, in_sign, in_op, out_ready,
    output in_ready, out_valid, exp_offset_num, significand, sign,
           complement_sign1, complement_sign2, max_exp, beat_cnt
  );
endinterface

// File: rtl/sig_shift_ctrl.sv
// Two-stage alignment controller: finds the largest exponent of four terms and
// the per-term right-shift. Define SIG_SHIFT_CLAMP_EN to saturate shift amounts.
module sig_shift_ctrl #(
  parameter int expWidth   = 4,
  parameter int sigWidth   = 4,
  parameter int low_expand = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  sig_shift_ctrl_if.slave bus
);

`ifdef SIG_SHIFT_CLAMP_EN
  // Beyond this shift the operand and its guard bits are entirely gone.
  localparam int SAT_LIMIT = sigWidth + 3 + low_expand;
`endif

  if (expWidth < 1 || sigWidth < 1 || low_expand < 0) begin : g_param_check
    $error("sig_shift_ctrl: illegal parameter set");
  end

  logic                  rdy_en_r;
  logic                  a_valid_r;
  logic [expWidth*4-1:0] a_exp_r;
  logic [sigWidth*4-1:0] a_sig_r;
  logic [3:0]            a_sign_r;
  logic [1:0]            a_op_r;

  logic                  b_free_s;
  logic                  acc_s;
  logic                  adv_s;
  logic                  hs_s;
  logic [3:0]            zero_s;
  logic [expWidth-1:0]   max_s;
  logic [expWidth*4-1:0] off_s;
  logic [3:0]            cs1_s;
  logic [3:0]            cs2_s;

  function automatic logic [7:0] op_masks(input logic [1:0] op);
    logic [7:0] m;
    case (op)
      2'b00:   m = {4'b0000, 4'b0000};
      2'b01:   m = {4'b0000, 4'b1100};
      2'b10:   m = {4'b1010, 4'b0101};
      2'b11:   m = {4'b0000, 4'b1111};
      default: m = {4'b0000, 4'b0000};
    endcase
    return m;
  endfunction

  function automatic logic [expWidth-1:0] sat_offset(input logic [expWidth-1:0] raw);
`ifdef SIG_SHIFT_CLAMP_EN
    logic [expWidth-1:0] r;
    if (int'(raw) > SAT_LIMIT) r = expWidth'(SAT_LIMIT);
    else                       r = raw;
    return r;
`else
    return raw;
`endif
  endfunction

  assign b_free_s     = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = rdy_en_r & !flush & (!a_valid_r | b_free_s);
  assign acc_s        = bus.in_valid & bus.in_ready;
  assign adv_s        = a_valid_r & b_free_s;
  assign hs_s         = bus.out_valid & bus.out_ready;

  // Max exponent over non-zero terms, per-term offsets and op masks from stage A.
  always_comb begin
    zero_s = 4'b0000;
    max_s  = '0;
    off_s  = '0;
    for (int i = 0; i < 4; i++) begin
      zero_s[i] = (a_exp_r[expWidth*i +: expWidth] == '0) &&
                  (a_sig_r[sigWidth*i +: sigWidth] == '0);
      max_s = (!zero_s[i] && (a_exp_r[expWidth*i +: expWidth] > max_s)) ?
              a_exp_r[expWidth*i +: expWidth] : max_s;
    end
    for (int i = 0; i < 4; i++) begin
      // A zero term is shifted by the full range so it contributes nothing.
      if (zero_s[i]) off_s[expWidth*i +: expWidth] = sat_offset('1);
      else           off_s[expWidth*i +: expWidth] = sat_offset(max_s - a_exp_r[expWidth*i +: expWidth]);
    end
    {cs1_s, cs2_s} = op_masks(a_op_r);
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_r <= 1'b0;
    else        rdy_en_r <= 1'b1;
  end

  // Stage A: capture of the accepted input beat, op included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_r <= 1'b0;
      a_exp_r   <= '0;
      a_sig_r   <= '0;
      a_sign_r  <= 4'b0000;
      a_op_r    <= 2'b00;
    end else if (flush) begin
      a_valid_r <= 1'b0;
    end else if (acc_s) begin
      a_valid_r <= 1'b1;
      a_exp_r   <= bus.in_exp;
      a_sig_r   <= bus.in_sig;
      a_sign_r  <= bus.in_sign;
      a_op_r    <= bus.in_op;
    end else if (adv_s) begin
      a_valid_r <= 1'b0;
    end
  end

  // Stage B: registered operand set, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid        <= 1'b0;
      bus.max_exp          <= '0;
      bus.exp_offset_num   <= '0;
      bus.significand      <= '0;
      bus.sign             <= 4'b0000;
      bus.complement_sign1 <= 4'b0000;
      bus.complement_sign2 <= 4'b0000;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (adv_s) begin
      bus.out_valid        <= 1'b1;
      bus.max_exp          <= max_s;
      bus.exp_offset_num   <= off_s;
      bus.significand      <= a_sig_r;
      bus.sign             <= a_sign_r;
      bus.complement_sign1 <= cs1_s;
      bus.complement_sign2 <= cs2_s;
    end else if (hs_s) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Completed output beat counter, free-running wrap at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bus.beat_cnt <= 16'd0;
    else if (hs_s) bus.beat_cnt <= bus.beat_cnt + 16'd1;
  end

endmodule
